// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: parametrised VGA timing and multi-sprite renderer with a 2-stage pixel pipeline.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_mode input that shows 8 vertical colour bars.
module vga_sprite_engine #(
   parameter int H_FP    = 64,
   parameter int H_SYNC  = 192,
   parameter int H_BP    = 304,
   parameter int H_VIS   = 1600,
   parameter int V_FP    = 1,
   parameter int V_SYNC  = 3,
   parameter int V_BP    = 46,
   parameter int V_VIS   = 1200,
   parameter int SPRITES = 4,
   parameter int SIZE    = 63,
   parameter int CW      = 12,
   parameter int RW      = 11
) (
   input  logic                         clock_162,
   input  logic                         rst,
   input  logic [SIZE*SIZE-1:0]         sprite,
   input  logic [SPRITES*12-1:0]        sprite_color,
   input  logic                         pos_wr,
   input  logic [$clog2(SPRITES)-1:0]   pos_idx,
   input  logic [RW-1:0]                pos_row,
   input  logic [CW-1:0]                pos_col,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                         test_mode,
`endif
   output logic [3:0]                   RED,
   output logic [3:0]                   GREEN,
   output logic [3:0]                   BLUE,
   output logic                         HSYNC,
   output logic                         VSYNC,
   output logic                         frame_start,
   output logic [RW-1:0]                vis_row,
   output logic [CW-1:0]                vis_col
);

   localparam int HOFF = H_FP + H_SYNC + H_BP;
   localparam int VOFF = V_FP + V_SYNC + V_BP;
   localparam int HT   = HOFF + H_VIS;
   localparam int VT   = VOFF + V_VIS;
   localparam int HALF = (SIZE - 1) / 2;
   localparam int IB   = $clog2(SIZE * SIZE);
   localparam logic signed [CW:0] HX = (CW+1)'(HALF);
   localparam logic signed [RW:0] HY = (RW+1)'(HALF);

   logic [CW-1:0] col, s1_vx;
   logic [RW-1:0] row, s1_vy;
   logic          s1_hs, s1_vs, s1_hv, s1_vv, s1_fs;
   logic [RW-1:0] sh_row [SPRITES];
   logic [RW-1:0] ac_row [SPRITES];
   logic [CW-1:0] sh_col [SPRITES];
   logic [CW-1:0] ac_col [SPRITES];
   logic signed [CW:0] dx;
   logic signed [RW:0] dy;
   logic          hit;
   logic [IB-1:0] idx;
   logic [11:0]   rgb;

   always_ff @(posedge clock_162 or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else begin
         col <= (col == CW'(HT - 1)) ? '0 : col + 1'b1;
         if (col == CW'(HT - 1)) row <= (row == RW'(VT - 1)) ? '0 : row + 1'b1;
      end
   end

   // Active positions take the shadow copy at (0,0); a same-cycle write only reaches shadow.
   always_ff @(posedge clock_162 or posedge rst) begin
      if (rst) begin
         sh_row <= '{default: '0};
         sh_col <= '{default: '0};
         ac_row <= '{default: '0};
         ac_col <= '{default: '0};
      end else begin
         if (col == '0 && row == '0) begin
            ac_row <= sh_row;
            ac_col <= sh_col;
         end
         if (pos_wr && int'(pos_idx) < SPRITES) begin
            sh_row[pos_idx] <= pos_row;
            sh_col[pos_idx] <= pos_col;
         end
      end
   end

   always_ff @(posedge clock_162 or posedge rst) begin
      if (rst) begin
         {s1_hs, s1_vs, s1_hv, s1_vv, s1_fs} <= '0;
         s1_vx <= '0;
         s1_vy <= '0;
      end else begin
         s1_hs <= col >= CW'(H_FP) && col < CW'(H_FP + H_SYNC);
         s1_vs <= row >= RW'(V_FP) && row < RW'(V_FP + V_SYNC);
         s1_hv <= col >= CW'(HOFF);
         s1_vv <= row >= RW'(VOFF);
         s1_fs <= col == '0 && row == '0;
         s1_vx <= col - CW'(HOFF);
         s1_vy <= row - RW'(VOFF);
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   logic [CW-1:0] bar;
   assign bar = s1_vx / CW'(H_VIS / 8);
`endif

   // Descending scan so the lowest-index opaque sprite overrides the rest.
   always_comb begin
      rgb = '0;
      dx  = '0;
      dy  = '0;
      hit = 1'b0;
      idx = '0;
      for (int i = SPRITES - 1; i >= 0; i--) begin
         dx  = $signed({1'b0, s1_vx}) - $signed({1'b0, ac_col[i]});
         dy  = $signed({1'b0, s1_vy}) - $signed({1'b0, ac_row[i]});
         hit = dx >= -HX && dx <= HX && dy >= -HY && dy <= HY;
         idx = hit ? IB'((int'(dy + HY)) * SIZE + int'(dx + HX)) : '0;
         if (hit && sprite[idx]) rgb = sprite_color[i*12 +: 12];
      end
      if (!(s1_hv && s1_vv)) rgb = '0;
`ifdef VGA_TEST_PATTERN_EN
      else if (test_mode) rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`endif
   end

   always_ff @(posedge clock_162 or posedge rst) begin
      if (rst) begin
         {RED, GREEN, BLUE} <= '0;
         HSYNC       <= 1'b1;
         VSYNC       <= 1'b1;
         frame_start <= 1'b0;
         vis_row     <= '0;
         vis_col     <= '0;
      end else begin
         {RED, GREEN, BLUE} <= rgb;
         HSYNC       <= ~s1_hs;
         VSYNC       <= ~s1_vs;
         frame_start <= s1_fs;
         vis_row     <= s1_vy;
         vis_col     <= s1_vx;
      end
   end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb_vga_sprite_engine: scoreboard bench for vga_sprite_engine on a small 16x12 raster.
// A reference model queues expected outputs per counter; a monitor pops and compares each cycle.
module tb_vga_sprite_engine;

   localparam int HF = 2, HS = 3, HB = 2, HV = 16;
   localparam int VF = 1, VS = 2, VB = 1, VV = 12;
   localparam int SP = 4, SZ = 3, HALF = 1, CW = 6, RW = 5, IB = 4;
   localparam int HOFF = HF + HS + HB, VOFF = VF + VS + VB;
   localparam int HT = HOFF + HV, VT = VOFF + VV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [SZ*SZ-1:0] sprite = '1;
   logic [SP*12-1:0] sprite_color = {12'hFFF, 12'h00F, 12'h0F0, 12'hF00};
   logic pos_wr = 1'b0;
   logic [1:0] pos_idx = '0;
   logic [RW-1:0] pos_row = '0;
   logic [CW-1:0] pos_col = '0;
   logic [3:0] RED, GREEN, BLUE;
   logic HSYNC, VSYNC, frame_start;
   logic [RW-1:0] vis_row;
   logic [CW-1:0] vis_col;

   vga_sprite_engine #(
      .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .H_VIS(HV),
      .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .V_VIS(VV),
      .SPRITES(SP), .SIZE(SZ), .CW(CW), .RW(RW)
   ) dut (
      .clock_162(clk), .rst(rst), .sprite(sprite), .sprite_color(sprite_color),
      .pos_wr(pos_wr), .pos_idx(pos_idx), .pos_row(pos_row), .pos_col(pos_col),
      .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .HSYNC(HSYNC), .VSYNC(VSYNC),
      .frame_start(frame_start), .vis_row(vis_row), .vis_col(vis_col)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0]   rgb;
      logic          hs, vs, fs, vis;
      logic [RW-1:0] vr;
      logic [CW-1:0] vc;
   } exp_t;

   exp_t q[$];
   int tc = 0, tr = 0;
   int shr[SP], shc[SP], acr[SP], acc[SP];
   int errors = 0, checks = 0;
   logic [11:0] fb [VV][HV];

   task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic pix(int r, int c, logic [11:0] v);
      chk($sformatf("fb[%0d][%0d]", r, c), 64'(fb[r][c]), 64'(v));
   endtask

   function automatic exp_t model(int c, int r);
      exp_t e;
      int vx, vy;
      e = '0;
      vx = c - HOFF;
      vy = r - VOFF;
      e.hs = !(c >= HF && c < HF + HS);
      e.vs = !(r >= VF && r < VF + VS);
      e.fs = c == 0 && r == 0;
      e.vis = vx >= 0 && vy >= 0;
      e.vr = vy[RW-1:0];
      e.vc = vx[CW-1:0];
      if (e.vis)
         for (int i = SP - 1; i >= 0; i--)
            if (vx >= acc[i] - HALF && vx <= acc[i] + HALF && vy >= acr[i] - HALF && vy <= acr[i] + HALF
                && sprite[IB'((vy - acr[i] + HALF) * SZ + vx - acc[i] + HALF)])
               e.rgb = sprite_color[i*12 +: 12];
      return e;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tc <= 0;
         tr <= 0;
         q.delete();
         shr <= '{default: 0};
         shc <= '{default: 0};
         acr <= '{default: 0};
         acc <= '{default: 0};
      end else begin
         q.push_back(model(tc, tr));
         if (tc == 0 && tr == 0) begin
            acr <= shr;
            acc <= shc;
         end
         if (pos_wr) begin
            shr[pos_idx] <= int'(pos_row);
            shc[pos_idx] <= int'(pos_col);
         end
         tc <= (tc == HT - 1) ? 0 : tc + 1;
         if (tc == HT - 1) tr <= (tr == VT - 1) ? 0 : tr + 1;
      end
   end

   int cyc = 0, last_fs = -1;
   exp_t me;
   logic popped;
   always @(negedge clk) begin
      cyc++;
      popped = q.size() >= 2;
      if (popped) me = q.pop_front();
      else begin
         me = '0;
         me.hs = 1'b1;
         me.vs = 1'b1;
         me.vis = 1'b1;
      end
      chk("pix", 64'({RED, GREEN, BLUE, HSYNC, VSYNC, frame_start}), 64'({me.rgb, me.hs, me.vs, me.fs}));
      if (me.vis) chk("coord", 64'({vis_row, vis_col}), 64'({me.vr, me.vc}));
      if (popped && me.vis) fb[me.vr][me.vc] = {RED, GREEN, BLUE};
      if (rst) last_fs = -1;
      else if (frame_start) begin
         if (last_fs >= 0) chk("fs_period", 64'(cyc - last_fs), 64'(HT * VT));
         last_fs = cyc;
      end
   end

   task automatic wait_rc(int r, int c);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(tr == r && tc == c) && n < 2000);
      if (n >= 2000) begin
         errors++;
         checks++;
         $display("FAIL wait_rc(%0d,%0d): timeout after %0d cycles", r, c, n);
      end
   endtask

   task automatic wr(int idx, int r, int c);
      pos_wr = 1'b1;
      pos_idx = 2'(idx);
      pos_row = RW'(r);
      pos_col = CW'(c);
      @(negedge clk);
      pos_wr = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_out", 64'({RED, GREEN, BLUE, HSYNC, VSYNC, frame_start, vis_row, vis_col}),
          64'({12'h000, 3'b110, 5'd0, 6'd0}));
      rst = 1'b0;
      wait_rc(2, 0);
      wr(0, 6, 8); wr(1, 0, 15); wr(2, 6, 8); wr(3, 11, 0);
      wait_rc(0, 3);
      pix(0, 0, 12'hF00); pix(1, 1, 12'hF00); pix(2, 2, 12'h000); pix(0, 2, 12'h000);
      wait_rc(9, 0);
      wr(0, 3, 3);
      wait_rc(0, 3);
      pix(6, 8, 12'hF00); pix(5, 7, 12'hF00); pix(7, 9, 12'hF00); pix(4, 8, 12'h000);
      pix(0, 15, 12'h0F0); pix(1, 14, 12'h0F0); pix(0, 0, 12'h000); pix(0, 13, 12'h000);
      pix(11, 0, 12'hFFF); pix(10, 1, 12'hFFF); pix(11, 2, 12'h000);
      wait_rc(0, 0);
      wr(3, 5, 12);
      wait_rc(0, 3);
      pix(3, 3, 12'hF00); pix(2, 2, 12'hF00); pix(6, 8, 12'h00F); pix(5, 7, 12'h00F);
      pix(11, 0, 12'hFFF); pix(5, 12, 12'h000);
      sprite = 9'b100_010_011;
      wait_rc(0, 3);
      pix(10, 0, 12'hFFF); pix(11, 0, 12'hFFF); pix(10, 1, 12'h000); pix(5, 12, 12'h000);
      pix(2, 2, 12'hF00); pix(2, 3, 12'hF00); pix(3, 3, 12'hF00); pix(4, 4, 12'hF00);
      pix(2, 4, 12'h000); pix(4, 2, 12'h000); pix(5, 7, 12'h00F); pix(5, 8, 12'h00F);
      pix(6, 8, 12'h00F); pix(7, 9, 12'h00F); pix(7, 7, 12'h000);
      wait_rc(9, 12);
      #3 rst = 1'b1;
      #1 chk("rst_async", 64'({RED, GREEN, BLUE, HSYNC, VSYNC, frame_start, vis_row, vis_col}),
             64'({12'h000, 3'b110, 5'd0, 6'd0}));
      pix(4, 11, 12'hFFF); pix(4, 12, 12'hFFF); pix(4, 13, 12'h000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_rc(15, 0);
      wait_rc(0, 3);
      pix(0, 0, 12'hF00); pix(1, 1, 12'hF00); pix(0, 1, 12'h000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
